// File: rtl/mfrc522_pkg.sv
// Shared MFRC522 definitions: register map, SPI address-byte encoding and
// the state codes of the register-access engine.
package mfrc522_pkg;

   localparam logic [5:0] COMMAND_REG    = 6'h01;
   localparam logic [5:0] COM_IRQ_REG    = 6'h04;
   localparam logic [5:0] FIFO_DATA_REG  = 6'h09;
   localparam logic [5:0] FIFO_LEVEL_REG = 6'h0A;
   localparam logic [5:0] TX_CONTROL_REG = 6'h14;
   localparam logic [5:0] VERSION_REG    = 6'h37;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_SEND = 3'd1;
   localparam state_t S_WAIT = 3'd2;
   localparam state_t S_PUSH = 3'd3;
   localparam state_t S_DONE = 3'd4;
   localparam state_t S_ERR  = 3'd5;

   // rw = 1 selects a register read; the LSB is always 0 on the MFRC522.
   function automatic logic [7:0] mfrc522_addr_byte(input logic rw, input logic [5:0] addr);
      return {rw, addr, 1'b0};
   endfunction

endpackage

// File: rtl/mfrc522_reg_if_if.sv
// Byte-command link between the register engine (master) and spi_master (slave).
// A byte transfers on a cycle with spi_cmd_valid && spi_cmd_ready; valid holds
// with stable data until then, and spi_cmd_done later pulses once with spi_rx_data.
interface mfrc522_reg_if_if;
   logic       spi_cmd_valid;
   logic [7:0] spi_tx_data;
   logic       spi_keep_cs;
   logic       spi_cmd_ready;
   logic [7:0] spi_rx_data;
   logic       spi_cmd_done;

   modport master (
      output spi_cmd_valid, spi_tx_data, spi_keep_cs,
      input  spi_cmd_ready, spi_rx_data, spi_cmd_done
   );

   modport slave (
      input  spi_cmd_valid, spi_tx_data, spi_keep_cs,
      output spi_cmd_ready, spi_rx_data, spi_cmd_done
   );
endinterface

// File: rtl/mfrc522_reg_if.sv
// MFRC522 register-access engine: turns read/write bursts into byte commands
// for spi_master, holding CS across the burst and guarding each byte with a timeout.
module mfrc522_reg_if
   import mfrc522_pkg::*;
#(
   parameter int MAX_LEN      = 64,
   parameter int LEN_W        = 7,
   parameter int TIMEOUT_CLKS = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [5:0]       req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             done,
   output logic             err,
   output logic             busy,
   mfrc522_reg_if_if.master spi,
   output state_t           dbg_state
);

   localparam int CNT_W = LEN_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

   state_t           state;
   logic             write_q;
   logic [5:0]       addr_q;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] cnt;
   logic [TO_W-1:0]  tcnt;
   logic             cmd_valid_q;
   logic [7:0]       tx_q;
   logic             keep_q;

   logic [CNT_W-1:0] len_ext;
   logic             last_done;
   logic             next_keep;
   logic [7:0]       next_rd_byte;
   logic             len_ok;
   logic             wait_to_wdata;
   logic             load_wr;

   // cnt is the index of the next byte to send, so after the final
   // handshake it sits one past the length.
   assign len_ext       = CNT_W'(len_q);
   assign last_done     = (cnt == len_ext + CNT_W'(1));
   assign next_keep     = (cnt != len_ext);
   assign next_rd_byte  = (cnt < len_ext) ? mfrc522_addr_byte(1'b1, addr_q) : 8'h00;
   assign len_ok        = (req_len != '0) && (req_len <= LEN_W'(MAX_LEN));
   assign wait_to_wdata = (state == S_WAIT) && spi.spi_cmd_done && write_q && !last_done;
   assign load_wr       = wr_valid && (((state == S_SEND) && !cmd_valid_q) || wait_to_wdata);

   assign req_ready         = (state == S_IDLE);
   assign busy              = (state != S_IDLE);
   assign wr_ready          = load_wr;
   assign dbg_state         = state;
   assign spi.spi_cmd_valid = cmd_valid_q;
   assign spi.spi_tx_data   = tx_q;
   assign spi.spi_keep_cs   = keep_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt         <= '0;
         tcnt        <= '0;
         cmd_valid_q <= 1'b0;
         tx_q        <= 8'h00;
         keep_q      <= 1'b0;
         rd_data     <= 8'h00;
         rd_valid    <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  len_q   <= req_len;
                  cnt     <= '0;
                  if (len_ok) begin
                     state       <= S_SEND;
                     cmd_valid_q <= 1'b1;
                     tx_q        <= mfrc522_addr_byte(!req_write, req_addr);
                     keep_q      <= 1'b1;
                  end else begin
                     state <= S_ERR;
                  end
               end
            end
            S_SEND: begin
               if (cmd_valid_q) begin
                  if (spi.spi_cmd_ready) begin
                     cmd_valid_q <= 1'b0;
                     cnt         <= cnt + CNT_W'(1);
                     // Preloaded so that ERR is entered with err landing
                     // exactly TIMEOUT_CLKS cycles after the handshake.
                     tcnt        <= TO_W'(2);
                     state       <= S_WAIT;
                  end
               end else if (wr_valid) begin
                  tx_q        <= wr_data;
                  keep_q      <= next_keep;
                  cmd_valid_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (spi.spi_cmd_done) begin
                  if (!write_q && (cnt >= CNT_W'(2))) begin
                     rd_data  <= spi.spi_rx_data;
                     rd_valid <= 1'b1;
                     state    <= S_PUSH;
                  end else if (last_done) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_SEND;
                     if (!write_q) begin
                        tx_q        <= next_rd_byte;
                        keep_q      <= next_keep;
                        cmd_valid_q <= 1'b1;
                     end else if (wr_valid) begin
                        tx_q        <= wr_data;
                        keep_q      <= next_keep;
                        cmd_valid_q <= 1'b1;
                     end
                  end
               end else if (tcnt >= TO_W'(TIMEOUT_CLKS - 1)) begin
                  state <= S_ERR;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end
            S_PUSH: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (last_done) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state       <= S_SEND;
                     tx_q        <= next_rd_byte;
                     keep_q      <= next_keep;
                     cmd_valid_q <= 1'b1;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            S_ERR: begin
               err   <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mfrc522_reg_if.sv
// Self-checking bench for mfrc522_reg_if with a randomized spi_master model,
// write-data producer and read-data consumer.
module tb_mfrc522_reg_if;
   import mfrc522_pkg::*;

   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;
   localparam int TO      = 40;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_write = 1'b0;
   logic [5:0]       req_addr = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic [7:0]       wr_data = '0;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_ready = 1'b0;
   logic             done;
   logic             err;
   logic             busy;
   state_t           dbg_state;

   mfrc522_reg_if_if spi();

   mfrc522_reg_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .err(err), .busy(busy),
      .spi(spi), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Logs and counters filled by the sampler, just before each rising edge.
   logic [7:0] tx_log[$];
   logic       keep_log[$];
   logic [7:0] rd_log[$];
   logic [7:0] rx_q[$];
   logic [7:0] wr_src[$];
   logic [7:0] exp_data[$];
   int  cyc = 0;
   int  done_cnt, err_cnt, wrr_cnt, valid_cyc, stall_viol;
   int  acc_cyc, first_valid_cyc, err_cyc, done_cyc, hs_cyc, cmd_done_cyc, rd_hs_cyc, rd_rise_cyc;
   bit  hs_cmd = 0, hs_wr = 0, hs_rd = 0, rd_valid_prev = 0;
   bit  hang = 0;
   int  stall_target = 0;

   initial forever begin
      @(negedge clk);
      #2;
      cyc++;
      hs_cmd = spi.spi_cmd_valid && spi.spi_cmd_ready;
      hs_wr  = wr_valid && wr_ready;
      hs_rd  = rd_valid && rd_ready;
      if (hs_cmd) begin
         tx_log.push_back(spi.spi_tx_data);
         keep_log.push_back(spi.spi_keep_cs);
         hs_cyc = cyc;
      end
      if (hs_rd) begin
         rd_log.push_back(rd_data);
         rd_hs_cyc = cyc;
      end
      if (spi.spi_cmd_valid) begin
         valid_cyc++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (rd_valid && spi.spi_cmd_valid) stall_viol++;
      if (rd_valid && !rd_valid_prev) rd_rise_cyc = cyc;
      rd_valid_prev = rd_valid;
      if (wr_ready) wrr_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (spi.spi_cmd_done) cmd_done_cyc = cyc;
   end

   // spi_master model: accepts a byte, then answers with cmd_done after 1..4 cycles.
   initial begin
      bit pending = 0;
      int dly = 0;
      spi.spi_cmd_ready = 1'b0;
      spi.spi_cmd_done  = 1'b0;
      spi.spi_rx_data   = 8'h00;
      forever begin
         @(negedge clk);
         spi.spi_cmd_done = 1'b0;
         if (!rst_n) begin
            pending = 0;
         end else if (hs_cmd) begin
            pending = 1;
            dly = $urandom_range(0, 3);
         end else if (pending && !hang) begin
            if (dly == 0) begin
               spi.spi_cmd_done = 1'b1;
               spi.spi_rx_data  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h5A;
               pending = 0;
            end else begin
               dly--;
            end
         end
         spi.spi_cmd_ready = !pending && ($urandom_range(0, 3) != 0);
      end
   end

   initial forever begin
      @(negedge clk);
      if (hs_wr && wr_src.size() > 0) wr_src.delete(0);
      if (wr_src.size() > 0 && $urandom_range(0, 2) != 0) begin
         wr_valid = 1'b1;
         wr_data  = wr_src[0];
      end else begin
         wr_valid = 1'b0;
         wr_data  = 8'($urandom);
      end
   end

   initial begin
      int stall = 0;
      forever begin
         @(negedge clk);
         if (hs_rd) stall = 0;
         if (rd_valid && stall >= stall_target) begin
            rd_ready = 1'b1;
         end else begin
            rd_ready = 1'b0;
            if (rd_valid) stall++;
         end
      end
   end

   task automatic clear_logs();
      tx_log.delete(); keep_log.delete(); rd_log.delete();
      done_cnt = 0; err_cnt = 0; wrr_cnt = 0; valid_cyc = 0; stall_viol = 0;
      first_valid_cyc = -1; acc_cyc = -1; err_cyc = -1; done_cyc = -1;
      cmd_done_cyc = -1; rd_hs_cyc = -1; rd_rise_cyc = -1;
   endtask

   task automatic start_req(input bit w, input logic [5:0] a, input int len);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = LEN_W'(len);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 6'($urandom);
      req_len   = LEN_W'($urandom);
   endtask

   task automatic wait_end(input int bound);
      int t = 0;
      while (done_cnt == 0 && err_cnt == 0 && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("wait_bound", 32'(t < bound), 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic run_txn(input bit w, input logic [5:0] a, input int len, input int stall);
      clear_logs();
      stall_target = stall;
      start_req(w, a, len);
      wait_end(2000);
   endtask

   // Expected bytes follow directly from the MFRC522 SPI framing rules.
   task automatic check_txn(input bit w, input logic [5:0] a, input int len);
      logic [7:0] exp_tx[$];
      int ai = int'(a);
      if (w) begin
         exp_tx.push_back(8'(2 * ai));
         foreach (exp_data[i]) exp_tx.push_back(exp_data[i]);
      end else begin
         for (int i = 0; i < len; i++) exp_tx.push_back(8'(128 + 2 * ai));
         exp_tx.push_back(8'h00);
      end
      chk("tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         chk($sformatf("tx_byte[%0d]", i), 32'(tx_log[i]), 32'(exp_tx[i]));
         chk($sformatf("keep_cs[%0d]", i), 32'(keep_log[i]), 32'(i != exp_tx.size() - 1));
      end
      if (w) begin
         chk("wr_ready_pulses", 32'(wrr_cnt), 32'(len));
         chk("done_after_cmd_done", 32'(done_cyc - cmd_done_cyc), 32'd1);
      end else begin
         chk("rd_count", 32'(rd_log.size()), 32'(len));
         for (int i = 0; i < len && i < rd_log.size(); i++)
            chk($sformatf("rd_byte[%0d]", i), 32'(rd_log[i]), 32'(exp_data[i]));
         chk("done_after_rd_hs", 32'(done_cyc - rd_hs_cyc), 32'd1);
      end
      chk("first_valid_lat", 32'(first_valid_cyc - acc_cyc), 32'd1);
      chk("done_cnt", 32'(done_cnt), 32'd1);
      chk("err_cnt", 32'(err_cnt), 32'd0);
      chk("valid_while_push", 32'(stall_viol), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cmd_valid"}, 32'(spi.spi_cmd_valid), 32'd0);
      chk({tag, "_keep_cs"}, 32'(spi.spi_keep_cs), 32'd0);
      chk({tag, "_tx_data"}, 32'(spi.spi_tx_data), 32'd0);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic version_read(input string tag);
      exp_data.delete(); rx_q.delete(); wr_src.delete();
      rx_q.push_back(8'h00); rx_q.push_back(8'h92);
      exp_data.push_back(8'h92);
      run_txn(1'b0, VERSION_REG, 1, 0);
      check_txn(1'b0, VERSION_REG, 1);
      chk({tag, "_rd_valid_lat"}, 32'(rd_rise_cyc - cmd_done_cyc), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit         w;
      logic [5:0] a;
      int         len;

      repeat (4) @(negedge clk);
      #1 check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      version_read("version");

      exp_data.delete(); rx_q.delete(); wr_src.delete();
      exp_data.push_back(8'h0F);
      wr_src = exp_data;
      run_txn(1'b1, COMMAND_REG, 1, 0);
      check_txn(1'b1, COMMAND_REG, 1);

      exp_data.delete(); rx_q.delete(); wr_src.delete();
      rx_q.push_back(8'($urandom));
      for (int i = 0; i < 3; i++) exp_data.push_back(8'($urandom));
      foreach (exp_data[i]) rx_q.push_back(exp_data[i]);
      run_txn(1'b0, FIFO_DATA_REG, 3, 10);
      check_txn(1'b0, FIFO_DATA_REG, 3);

      for (int n = 0; n < 20; n++) begin
         w   = 1'($urandom_range(0, 1));
         a   = 6'($urandom_range(0, 63));
         len = $urandom_range(1, 6);
         exp_data.delete(); rx_q.delete(); wr_src.delete();
         for (int i = 0; i < len; i++) exp_data.push_back(8'($urandom));
         if (w) begin
            wr_src = exp_data;
         end else begin
            rx_q.push_back(8'($urandom));
            foreach (exp_data[i]) rx_q.push_back(exp_data[i]);
         end
         run_txn(w, a, len, $urandom_range(0, 3));
         check_txn(w, a, len);
      end

      // spi_master that never finishes the byte.
      rx_q.delete(); wr_src.delete();
      hang = 1;
      run_txn(1'b0, VERSION_REG, 1, 0);
      chk("timeout_err_cnt", 32'(err_cnt), 32'd1);
      chk("timeout_done_cnt", 32'(done_cnt), 32'd0);
      chk("timeout_latency", 32'(err_cyc - hs_cyc), 32'(TO));
      hang = 0;
      apply_reset();

      run_txn(1'b0, VERSION_REG, 0, 0);
      chk("len0_err_cnt", 32'(err_cnt), 32'd1);
      chk("len0_valid_cycles", 32'(valid_cyc), 32'd0);
      chk("len0_err_lat", 32'(err_cyc - acc_cyc), 32'd2);
      chk("len0_done_cnt", 32'(done_cnt), 32'd0);
      chk("len0_req_ready", 32'(req_ready), 32'd1);

      run_txn(1'b1, FIFO_DATA_REG, MAX_LEN + 1, 0);
      chk("len65_err_cnt", 32'(err_cnt), 32'd1);
      chk("len65_valid_cycles", 32'(valid_cyc), 32'd0);
      chk("len65_err_lat", 32'(err_cyc - acc_cyc), 32'd2);
      chk("len65_req_ready", 32'(req_ready), 32'd1);

      // Reset in the middle of a len-4 read, away from any clock edge.
      begin
         int t = 0;
         exp_data.delete(); rx_q.delete(); wr_src.delete();
         for (int i = 0; i < 5; i++) rx_q.push_back(8'($urandom_range(1, 255)));
         clear_logs();
         stall_target = 0;
         start_req(1'b0, FIFO_LEVEL_REG, 4);
         while (tx_log.size() < 2 && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("midreset_reach_byte2", 32'(t < 200), 32'd1);
         #3 rst_n = 1'b0;
         #1 check_idle("midreset");
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         chk("midreset_done_cnt", 32'(done_cnt), 32'd0);
         chk("midreset_err_cnt", 32'(err_cnt), 32'd0);
         @(negedge clk);
      end
      version_read("post_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
